// File: rtl/servo_pkg.sv
// Shared servo PWM definitions: timing defaults, decoder FSM states and
// the position clamp used when turning a divider quotient into a position.
package servo_pkg;

    localparam int unsigned PERIOD    = 1000000;  // 20 ms frame at 50 MHz
    localparam int unsigned MIN_W     = 50000;    // width for position 0 (1 ms)
    localparam int unsigned STEP      = 196;      // cycles per position LSB
    localparam int unsigned MIN_VALID = 25000;    // shortest accepted pulse
    localparam int unsigned MAX_VALID = 150000;   // longest accepted pulse
    localparam int unsigned TIMEOUT   = 1250000;  // 25 ms without a rise

    // Fixed iteration count of the width divider (17-bit dividend)
    localparam logic [4:0] DIV_ITERS = 5'd17;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        WAIT_LOW  = 2'd2,
        DIV       = 2'd3
    } state_t;

    // Saturate a quotient to the 8-bit position scale
    function automatic logic [7:0] clamp_position(input logic [16:0] q);
        logic [7:0] result;
        if (q > 17'd255) begin
            result = 8'd255;
        end else begin
            result = q[7:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/servo_width_div.sv
// Restoring divider: 17-bit dividend by 8-bit divisor, always 17 iterations.
// start loads the operands; done is a one-cycle strobe with q valid.
// Asserting reset aborts any division in progress.
module servo_width_div (
    input  logic        clk50mhz,
    input  logic        reset,
    input  logic        start,
    input  logic [16:0] dividend,
    input  logic [7:0]  divisor,
    output logic [16:0] q,
    output logic        done
);
    import servo_pkg::*;

    logic [4:0]  count_r;
    logic [7:0]  rem_r;
    logic [16:0] quo_r;
    logic        done_r;
    logic [8:0]  trial_s;
    logic [7:0]  diff_s;
    logic        take_s;

    // One restoring step: shift next dividend bit into the remainder and trial-subtract
    always_comb begin
        trial_s = {rem_r, quo_r[16]};
        diff_s  = trial_s[7:0] - divisor;
        take_s  = (trial_s >= {1'b0, divisor});
    end

    // Iteration counter, remainder and quotient shift register
    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            count_r <= 5'd0;
            rem_r   <= 8'd0;
            quo_r   <= 17'd0;
            done_r  <= 1'b0;
        end else if (start) begin
            count_r <= DIV_ITERS;
            rem_r   <= 8'd0;
            quo_r   <= dividend;
            done_r  <= 1'b0;
        end else if (count_r != 5'd0) begin
            rem_r   <= take_s ? diff_s : trial_s[7:0];
            quo_r   <= {quo_r[15:0], take_s};
            count_r <= count_r - 5'd1;
            done_r  <= (count_r == 5'd1);
        end else begin
            done_r  <= 1'b0;
        end
    end

    assign q    = quo_r;
    assign done = done_r;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures pwm_in high time in clk50mhz cycles, decodes it to
// position = min(floor((width - MIN_W) / STEP), 255), and flags runt pulses,
// over-long pulses and loss of signal.
module servo_pwm_decoder #(
    parameter int unsigned MIN_W     = servo_pkg::MIN_W,
    parameter int unsigned STEP      = servo_pkg::STEP,
    parameter int unsigned MIN_VALID = servo_pkg::MIN_VALID,
    parameter int unsigned MAX_VALID = servo_pkg::MAX_VALID,
    parameter int unsigned TIMEOUT   = servo_pkg::TIMEOUT
) (
    input  logic        clk50mhz,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [7:0]  position,
    output logic [17:0] pulse_width,
    output logic        pos_valid,
    output logic        err_short,
    output logic        err_long,
    output logic        signal_lost
);
    import servo_pkg::*;

    localparam logic [17:0] MIN_W_C     = 18'(MIN_W);
    localparam logic [7:0]  STEP_C      = 8'(STEP);
    localparam logic [17:0] MIN_VALID_C = 18'(MIN_VALID);
    localparam logic [17:0] MAX_VALID_C = 18'(MAX_VALID);
    localparam logic [20:0] TIMEOUT_C   = 21'(TIMEOUT);

    logic        sync0_r;
    logic        sync1_r;
    logic        prev_r;
    logic        rise_s;
    logic        fall_s;

    state_t      state_r;
    state_t      state_s;
    logic [17:0] width_r;
    logic [17:0] width_s;
    logic [17:0] latched_r;
    logic [17:0] latched_s;
    logic        pos_valid_s;
    logic        err_short_s;
    logic        err_long_s;

    logic        div_start_s;
    logic [16:0] div_dividend_s;
    logic [16:0] div_q_s;
    logic        div_done_s;

    logic [20:0] wd_r;

    // Two-flop synchronizer for the asynchronous pin plus a delayed copy for edges
    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            sync0_r <= 1'b0;
            sync1_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync0_r <= pwm_in;
            sync1_r <= sync0_r;
            prev_r  <= sync1_r;
        end
    end

    assign rise_s = sync1_r & ~prev_r;
    assign fall_s = ~sync1_r & prev_r;

    // Offset above MIN_W fed to the divider; narrower accepted pulses decode to 0
    always_comb begin
        if (width_r > MIN_W_C) begin
            div_dividend_s = 17'(width_r - MIN_W_C);
        end else begin
            div_dividend_s = 17'd0;
        end
    end

    servo_width_div u_div (
        .clk50mhz (clk50mhz),
        .reset    (reset),
        .start    (div_start_s),
        .dividend (div_dividend_s),
        .divisor  (STEP_C),
        .q        (div_q_s),
        .done     (div_done_s)
    );

    // Next-state, width counting and strobe decisions
    always_comb begin
        state_s     = state_r;
        width_s     = width_r;
        latched_s   = latched_r;
        div_start_s = 1'b0;
        pos_valid_s = 1'b0;
        err_short_s = 1'b0;
        err_long_s  = 1'b0;
        case (state_r)
            WAIT_RISE: begin
                if (rise_s) begin
                    width_s = 18'd1;
                    state_s = HIGH;
                end else begin
                    state_s = WAIT_RISE;
                end
            end
            HIGH: begin
                // Without a fall the synchronized input is still high here
                if (fall_s) begin
                    if (width_r < MIN_VALID_C) begin
                        err_short_s = 1'b1;
                        state_s     = WAIT_RISE;
                    end else begin
                        latched_s   = width_r;
                        div_start_s = 1'b1;
                        state_s     = DIV;
                    end
                end else if (width_r == MAX_VALID_C) begin
                    width_s    = width_r + 18'd1;
                    err_long_s = 1'b1;
                    state_s    = WAIT_LOW;
                end else begin
                    width_s = width_r + 18'd1;
                end
            end
            WAIT_LOW: begin
                if (fall_s) begin
                    state_s = WAIT_RISE;
                end else begin
                    state_s = WAIT_LOW;
                end
            end
            DIV: begin
                // Rises here are deliberately ignored; that pulse goes unmeasured
                if (div_done_s) begin
                    pos_valid_s = 1'b1;
                    state_s     = WAIT_RISE;
                end else begin
                    state_s = DIV;
                end
            end
            default: begin
                state_s = WAIT_RISE;
            end
        endcase
    end

    // FSM state, width counter and registered outputs
    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            state_r     <= WAIT_RISE;
            width_r     <= 18'd0;
            latched_r   <= 18'd0;
            position    <= 8'd0;
            pulse_width <= 18'd0;
            pos_valid   <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
        end else begin
            state_r   <= state_s;
            width_r   <= width_s;
            latched_r <= latched_s;
            pos_valid <= pos_valid_s;
            err_short <= err_short_s;
            err_long  <= err_long_s;
            if (pos_valid_s) begin
                position    <= clamp_position(div_q_s);
                pulse_width <= latched_r;
            end else begin
                position    <= position;
                pulse_width <= pulse_width;
            end
        end
    end

    // Watchdog: cycles since the last rise, saturating at TIMEOUT
    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            wd_r <= 21'd0;
        end else if (rise_s) begin
            wd_r <= 21'd0;
        end else if (wd_r != TIMEOUT_C) begin
            wd_r <= wd_r + 21'd1;
        end else begin
            wd_r <= wd_r;
        end
    end

    // Loss-of-signal level: set by watchdog expiry, cleared by a decoded pulse
    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            signal_lost <= 1'b1;
        end else if (wd_r == TIMEOUT_C) begin
            signal_lost <= 1'b1;
        end else if (pos_valid_s) begin
            signal_lost <= 1'b0;
        end else begin
            signal_lost <= signal_lost;
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Self-checking bench for servo_pwm_decoder, run with scaled-down timing
// parameters so that every scenario fits in a short simulation.
module tb_servo_pwm_decoder;

    localparam int MIN_W     = 200;
    localparam int STEP      = 3;
    localparam int MIN_VALID = 100;
    localparam int MAX_VALID = 1100;
    localparam int TIMEOUT   = 3000;

    logic        clk50mhz = 1'b0;
    logic        reset    = 1'b1;
    logic        pwm_in   = 1'b0;
    logic [7:0]  position;
    logic [17:0] pulse_width;
    logic        pos_valid;
    logic        err_short;
    logic        err_long;
    logic        signal_lost;

    int total = 0;
    int bad   = 0;
    int exp_pos = 0;
    int exp_pw  = 0;
    int n_valid = 0;
    int n_short = 0;
    int n_long  = 0;

    servo_pwm_decoder #(
        .MIN_W     (MIN_W),
        .STEP      (STEP),
        .MIN_VALID (MIN_VALID),
        .MAX_VALID (MAX_VALID),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk50mhz    (clk50mhz),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .position    (position),
        .pulse_width (pulse_width),
        .pos_valid   (pos_valid),
        .err_short   (err_short),
        .err_long    (err_long),
        .signal_lost (signal_lost)
    );

    always #10 clk50mhz = ~clk50mhz;

    // Running strobe counts, sampled mid-cycle
    always @(negedge clk50mhz) begin
        if (pos_valid) n_valid <= n_valid + 1;
        if (err_short) n_short <= n_short + 1;
        if (err_long)  n_long  <= n_long + 1;
    end

    // Reference decode straight from the position scale definition
    function automatic int ref_pos(input int w);
        int off;
        int q;
        off = (w > MIN_W) ? (w - MIN_W) : 0;
        q   = off / STEP;
        return (q > 255) ? 255 : q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive a pulse sampled high on exactly w clock edges, then watch 30 edges after the fall
    task automatic pulse_and_measure(input int w, output int kv, output int ks, output int nv,
                                     output int ps, output int pws);
        @(negedge clk50mhz);
        pwm_in = 1'b1;
        repeat (w) @(posedge clk50mhz);
        @(negedge clk50mhz);
        pwm_in = 1'b0;
        kv = -1; ks = -1; nv = 0; ps = -1; pws = -1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk50mhz);
            #1;
            if (pos_valid) begin
                nv++;
                if (kv < 0) begin
                    kv  = k;
                    ps  = int'(position);
                    pws = int'(pulse_width);
                end
            end
            if (err_short && ks < 0) ks = k;
        end
    endtask

    // One pulse followed by a low gap, checked against the reference rules
    task automatic do_frame(input int w, input int gap);
        int kv, ks, nv, ps, pws, nl0;
        nl0 = n_long;
        pulse_and_measure(w, kv, ks, nv, ps, pws);
        if (w < MIN_VALID) begin
            chk("short_latency", ks, 2);
            chk("short_no_valid", nv, 0);
            chk("short_pos_hold", position, exp_pos);
            chk("short_pw_hold", pulse_width, exp_pw);
        end else if (w <= MAX_VALID) begin
            exp_pos = ref_pos(w);
            exp_pw  = w;
            chk("valid_latency", kv, 20);
            chk("valid_once", nv, 1);
            chk("position", ps, exp_pos);
            chk("pulse_width", pws, exp_pw);
            chk("no_short", ks, -1);
            chk("lost_cleared", signal_lost, 0);
        end else begin
            chk("long_strobe", n_long - nl0, 1);
            chk("long_no_valid", nv, 0);
            chk("long_no_short", ks, -1);
            chk("long_pos_hold", position, exp_pos);
        end
        repeat (gap) @(negedge clk50mhz);
    endtask

    initial begin
        int kv, ks, nv, ps, pws, v0, s0, l0, first_long, w;

        // Reset state
        repeat (4) @(posedge clk50mhz);
        #1;
        chk("rst_position", position, 0);
        chk("rst_pulse_width", pulse_width, 0);
        chk("rst_pos_valid", pos_valid, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_err_long", err_long, 0);
        chk("rst_signal_lost", signal_lost, 1);
        @(negedge clk50mhz);
        reset = 1'b0;
        repeat (5) @(negedge clk50mhz);

        // Directed widths: nominal points and decode boundaries
        do_frame(MIN_W, 40);                    // position 0
        do_frame(MIN_W + 128 * STEP, 40);       // position 128
        do_frame(1000, 40);                     // beyond 255 range, clamps
        do_frame(150, 40);                      // below MIN_W, decodes 0
        do_frame(MIN_VALID, 40);                // shortest accepted
        do_frame(MIN_VALID - 1, 40);            // runt
        do_frame(10, 40);                       // runt, much shorter
        do_frame(MIN_W + 255 * STEP - 1, 40);   // 254
        do_frame(MIN_W + 255 * STEP, 40);       // 255
        do_frame(MAX_VALID, 40);                // longest accepted
        do_frame(MAX_VALID + 1, 40);            // over-long by one

        // Held high well past MAX_VALID: err_long timing, then nothing decoded
        l0 = n_long;
        v0 = n_valid;
        first_long = -1;
        @(negedge clk50mhz);
        pwm_in = 1'b1;
        for (int i = 1; i <= MAX_VALID + 300; i++) begin
            @(posedge clk50mhz);
            #1;
            if (err_long && first_long < 0) first_long = i;
        end
        @(negedge clk50mhz);
        pwm_in = 1'b0;
        repeat (40) @(negedge clk50mhz);
        chk("long_edge", first_long, MAX_VALID + 3);
        chk("long_once", n_long - l0, 1);
        chk("long_hold_no_valid", n_valid - v0, 0);

        // Rise during the divide window is ignored and raises no error
        v0 = n_valid;
        s0 = n_short;
        l0 = n_long;
        w  = 500;
        @(negedge clk50mhz);
        pwm_in = 1'b1;
        repeat (w) @(posedge clk50mhz);
        @(negedge clk50mhz);
        pwm_in = 1'b0;
        repeat (6) @(negedge clk50mhz);
        pwm_in = 1'b1;
        repeat (300) @(negedge clk50mhz);
        pwm_in = 1'b0;
        repeat (60) @(negedge clk50mhz);
        exp_pos = ref_pos(w);
        exp_pw  = w;
        chk("div_rise_valid_count", n_valid - v0, 1);
        chk("div_rise_no_short", n_short - s0, 0);
        chk("div_rise_no_long", n_long - l0, 0);
        chk("div_rise_position", position, exp_pos);
        chk("div_rise_width", pulse_width, exp_pw);

        // Randomized loopback-style sweep: any position, jitter within one STEP
        for (int f = 0; f < 32; f++) begin
            int p;
            p = $urandom_range(0, 255);
            do_frame(MIN_W + p * STEP + $urandom_range(0, STEP - 1), $urandom_range(25, 60));
        end
        // Random widths anywhere in the accepted range
        for (int f = 0; f < 8; f++) begin
            do_frame($urandom_range(MIN_VALID, MAX_VALID), $urandom_range(25, 60));
        end

        // Loss of signal, then recovery on a decoded pulse
        do_frame(300, 1);
        repeat (TIMEOUT - 300 - 80) @(negedge clk50mhz);
        chk("lost_not_yet", signal_lost, 0);
        repeat (150) @(negedge clk50mhz);
        chk("lost_set", signal_lost, 1);
        do_frame(MIN_W + 51 * STEP, 40);
        chk("recover_position", position, 51);

        // Reset in the middle of a pulse
        @(negedge clk50mhz);
        pwm_in = 1'b1;
        repeat (250) @(negedge clk50mhz);
        reset = 1'b1;
        repeat (3) @(posedge clk50mhz);
        #1;
        chk("midrst_position", position, 0);
        chk("midrst_pulse_width", pulse_width, 0);
        chk("midrst_pos_valid", pos_valid, 0);
        chk("midrst_signal_lost", signal_lost, 1);
        @(negedge clk50mhz);
        reset = 1'b0;
        repeat (330) @(negedge clk50mhz);
        pwm_in = 1'b0;
        repeat (60) @(negedge clk50mhz);
        do_frame(MIN_W + 128 * STEP, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/servo_pwm_decoder.md
# servo_pwm_decoder

Receive-side counterpart to the servo PWM generator. Measures the high time of an incoming 50 Hz servo/RC PWM signal in `clk50mhz` cycles and decodes it to the same 8-bit position scale the generator uses (width = MIN_W + position·STEP). Flags runt pulses, over-long pulses and loss of signal. Used for loopback self-test of the generator and for reading external RC receivers.

## Interface
- MIN_W, 50000: width in cycles for position 0 (1 ms)
- STEP, 196: cycles per position LSB
- MIN_VALID, 25000: shortest accepted pulse (0.5 ms)
- MAX_VALID, 150000: longest accepted pulse (3 ms)
- TIMEOUT, 1250000: cycles without a rising edge before signal_lost (25 ms)
- clk50mhz  in  1  50 MHz clock
- reset  in  1  synchronous, active-high
- pwm_in  in  1  asynchronous PWM input
- position  out  8  last decoded position
- pulse_width  out  18  last accepted raw width in cycles
- pos_valid  out  1  one-cycle strobe: position/pulse_width updated
- err_short  out  1  one-cycle strobe: pulse < MIN_VALID discarded
- err_long  out  1  one-cycle strobe: pulse > MAX_VALID discarded
- signal_lost  out  1  level: no rising edge for TIMEOUT cycles

## Operation
- pwm_in passes through a 2-flop synchronizer (s1 = second stage); a registered copy of s1 gives rise = s1 & ~prev and fall = ~s1 & prev.
- FSM states: WAIT_RISE, HIGH, WAIT_LOW, DIV.
  - WAIT_RISE: on rise, width counter := 1, go to HIGH.
  - HIGH: increment width each cycle s1 = 1. On fall: if width < MIN_VALID, pulse err_short, go to WAIT_RISE; else latch width, start divider, go to DIV. If width reaches MAX_VALID+1 while high: pulse err_long, go to WAIT_LOW.
  - WAIT_LOW: on fall, go to WAIT_RISE. No measurement.
  - DIV: wait for divider done; register results, pulse pos_valid, go to WAIT_RISE. Rising edges during DIV are ignored; that pulse is not measured and raises no error.
- Decode: off = width − MIN_W if width > MIN_W else 0; q = off / STEP (floor); position = min(q, 255). Widths below MIN_W but ≥ MIN_VALID give 0; above MIN_W+255·STEP up to MAX_VALID give 255; neither is an error.
- Watchdog: 21-bit counter cleared on every rise (any state), saturates at TIMEOUT; reaching TIMEOUT sets signal_lost. signal_lost clears on pos_valid.
- Reset mid-operation: FSM to WAIT_RISE, divider aborted, all counters cleared, synchronizer and prev cleared to 0. A pulse already high at reset release is not measured: the first rise seen is its start only if s1 was low first.

## Timing
- Reset values: position 0, pulse_width 0, pos_valid 0, err_short 0, err_long 0, signal_lost 1.
- Measured width = number of clocks s1 is high = pin high time in clocks (exact for registered sources such as the generator).
- Latency: let clock edge E0 be the first that samples pwm_in low. pos_valid is high in the cycle after edge E0+20: 2 sync, 1 edge detect/latch, 17 divider iterations.
- err_short is high in the cycle after E0+2. err_long is high in the cycle after the edge at which width reaches MAX_VALID+1.
- All strobes last exactly one cycle. position and pulse_width are stable between strobes.

## Structure
- Shared package servo_pkg holds MIN_W, STEP, MIN_VALID, MAX_VALID, TIMEOUT defaults, the state enum, and PERIOD = 1000000. The generator also uses PERIOD.
- Sub-module servo_width_div: restoring divider, 17-bit dividend by 8-bit divisor, fixed 17 iterations, start/done handshake, synchronous abort on reset. Produces q; the parent applies the 255 clamp.

## Test plan
- Reset, then drive the generator output at position 0 → width 50000, position 0, pos_valid 20 clocks after the falling edge; signal_lost drops.
- Pulse 50000+128·196 = 75088 cycles → position 128, pulse_width 75088; sweep positions 0..255 via loopback → exact match each frame.
- Pulse 110000 → position 255, no error; pulse 40000 → position 0, no error.
- Pulse 1000 cycles → err_short strobe, no pos_valid, position unchanged.
- Hold high 200000 cycles → err_long at width 150001, no pos_valid; hold low 1250000 cycles → signal_lost = 1; next 60000 pulse → position 51, signal_lost = 0.
- Assert reset midway through a 75088 pulse → outputs at reset values; the next full pulse decodes correctly.
